// File: rtl/gshare_btb_predictor.sv
// Multi-lane gshare direction predictor with a direct-mapped BTB.
// Predictions are registered; resolved branches train the tables and repair the GHR.
module gshare_btb_predictor #(
  parameter int unsigned FETCH_W   = 3,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned BTB_TAG_W = 10,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned XLEN      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FETCH_W-1:0]             fetch_en,
  input  logic [FETCH_W-1:0][XLEN-1:0]   fetch_pc,
  output logic [FETCH_W-1:0]             pred_valid,
  output logic [FETCH_W-1:0]             pred_taken,
  output logic [FETCH_W-1:0][XLEN-1:0]   pred_target,
  output logic [GHR_W-1:0]               pred_ghr,
  input  logic                           upd_en,
  input  logic [XLEN-1:0]                upd_pc,
  input  logic                           upd_taken,
  input  logic [XLEN-1:0]                upd_target,
  input  logic [GHR_W-1:0]               upd_ghr,
  input  logic                           upd_mispredict
);

  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned PHT_N = 1 << GHR_W;

  logic [BTB_N-1:0]       btb_valid_q;
  logic [BTB_TAG_W-1:0]   btb_tag_q [BTB_N];
  logic [XLEN-1:0]        btb_tgt_q [BTB_N];
  logic [1:0]             pht_q     [PHT_N];
  logic [GHR_W-1:0]       ghr_q, ghr_d;

  logic [FETCH_W-1:0]           pred_valid_q, pred_valid_d;
  logic [FETCH_W-1:0]           pred_taken_q, pred_taken_d;
  logic [FETCH_W-1:0][XLEN-1:0] pred_target_q, pred_target_d;
  logic [GHR_W-1:0]             pred_ghr_q;

  logic [BTB_IDX_W-1:0] lane_idx;
  logic                 lane_hit;
  logic                 lane_tk;
  logic                 squash;

  logic [BTB_IDX_W-1:0] upd_idx;
  logic [BTB_TAG_W-1:0] upd_tag;
  logic [GHR_W-1:0]     upd_pidx;
  logic                 unused_upd_pc;

  assign upd_idx       = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag       = upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
  assign upd_pidx      = upd_pc[GHR_W+1:2] ^ upd_ghr;
  assign unused_upd_pc = ^upd_pc;

  // Per-lane lookup; the first taken lane squashes the rest and history shifts per surviving hit.
  always_comb begin
    ghr_d         = ghr_q;
    squash        = 1'b0;
    pred_valid_d  = '0;
    pred_taken_d  = '0;
    pred_target_d = '0;
    lane_idx      = '0;
    lane_hit      = 1'b0;
    lane_tk       = 1'b0;
    for (int unsigned l = 0; l < FETCH_W; l++) begin
      lane_idx = fetch_pc[l][BTB_IDX_W+1:2];
      lane_hit = fetch_en[l] && btb_valid_q[lane_idx] &&
                 (btb_tag_q[lane_idx] == fetch_pc[l][BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2]);
      lane_tk  = lane_hit && pht_q[fetch_pc[l][GHR_W+1:2] ^ ghr_q][1];
      pred_target_d[l] = fetch_pc[l] + XLEN'(4);
      if (!squash) begin
        pred_valid_d[l] = lane_hit;
        pred_taken_d[l] = lane_tk;
        if (lane_tk) pred_target_d[l] = btb_tgt_q[lane_idx];
        if (lane_hit) ghr_d = {ghr_d[GHR_W-2:0], lane_tk};
        squash = lane_tk;
      end
    end
    if (upd_en && upd_mispredict) ghr_d = {upd_ghr[GHR_W-2:0], upd_taken};
  end

  // Resettable state: history, outputs, valid bits and direction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q         <= '0;
      pred_valid_q  <= '0;
      pred_taken_q  <= '0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
      btb_valid_q   <= '0;
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else begin
      ghr_q         <= ghr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_ghr_q    <= ghr_q;
      if (upd_en) begin
        if (upd_taken) begin
          btb_valid_q[upd_idx] <= 1'b1;
          if (pht_q[upd_pidx] != 2'b11) pht_q[upd_pidx] <= pht_q[upd_pidx] + 2'd1;
        end else if (pht_q[upd_pidx] != 2'b00) begin
          pht_q[upd_pidx] <= pht_q[upd_pidx] - 2'd1;
        end
      end
    end
  end

  // Tag/target payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      btb_tag_q[upd_idx] <= upd_tag;
      btb_tgt_q[upd_idx] <= upd_target;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_ghr    = pred_ghr_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed scenarios plus a
// randomized run against a behavioural table model.
module tb_gshare_btb_predictor;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        fetch_en;
  logic [2:0][31:0]  fetch_pc;
  logic [2:0]        pred_valid, pred_taken;
  logic [2:0][31:0]  pred_target;
  logic [7:0]        pred_ghr;
  logic              upd_en, upd_taken, upd_mispredict;
  logic [31:0]       upd_pc, upd_target;
  logic [7:0]        upd_ghr;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_pht   [256];
  int unsigned m_ghr;
  bit   [2:0]  e_valid, e_taken;
  logic [31:0] e_tgt [3];
  logic [7:0]  e_ghr;

  always #5 clk = ~clk;

  gshare_btb_predictor dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ghr(pred_ghr), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
  );

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  // Predict from the pre-edge tables, then apply the update.
  task automatic model_step();
    int unsigned g, idx, tag, pi;
    bit squashed, hit, tk;
    g = m_ghr;
    squashed = 0;
    e_ghr = 8'(m_ghr);
    for (int l = 0; l < 3; l++) begin
      idx = (fetch_pc[l] >> 2) % 64;
      tag = (fetch_pc[l] >> 8) % 1024;
      pi  = ((fetch_pc[l] >> 2) % 256) ^ m_ghr;
      hit = fetch_en[l] && m_valid[idx] && (m_tag[idx] == tag);
      tk  = hit && (m_pht[pi] >= 2);
      e_valid[l] = 0;
      e_taken[l] = 0;
      e_tgt[l]   = fetch_pc[l] + 4;
      if (!squashed) begin
        e_valid[l] = hit;
        e_taken[l] = tk;
        if (tk) e_tgt[l] = m_tgt[idx];
        if (hit) g = (g * 2 + (tk ? 1 : 0)) % 256;
        if (tk) squashed = 1;
      end
    end
    if (upd_en) begin
      pi = ((upd_pc >> 2) % 256) ^ upd_ghr;
      if (upd_taken) begin
        if (m_pht[pi] < 3) m_pht[pi]++;
        idx = (upd_pc >> 2) % 64;
        m_valid[idx] = 1;
        m_tag[idx]   = (upd_pc >> 8) % 1024;
        m_tgt[idx]   = upd_target;
      end else if (m_pht[pi] > 0) begin
        m_pht[pi]--;
      end
      if (upd_mispredict) g = (upd_ghr * 2 + (upd_taken ? 1 : 0)) % 256;
    end
    m_ghr = g;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_en = '0; fetch_pc = '0;
    upd_en = 0; upd_pc = '0; upd_taken = 0; upd_target = '0; upd_ghr = '0; upd_mispredict = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input logic [7:0] g, input bit mp);
    idle();
    upd_en = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = g; upd_mispredict = mp;
    cycle();
    idle();
  endtask

  task automatic set_ghr(input logic [7:0] g);
    upd(32'h5010, g[0], 32'h5010, {1'b0, g[7:1]}, 1);
  endtask

  task automatic fetch1(input logic [31:0] pc);
    idle();
    fetch_en = 3'b001; fetch_pc[0] = pc;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 3'b0 || pred_taken !== 3'b0 || pred_target !== '0 || pred_ghr !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b taken=%b ghr=%h exp all zero", pred_valid, pred_taken, pred_ghr);
    end
    rst = 0;
  endtask

  task automatic test_cold_miss();
    fetch1(32'h1000);
    checks++;
    if (pred_valid !== 3'b000 || pred_target[0] !== 32'h1004 || pred_ghr !== 8'h00) begin
      failures++;
      $display("FAIL cold_miss got valid=%b tgt0=%h ghr=%h exp 000/00001004/00", pred_valid, pred_target[0], pred_ghr);
    end
  endtask

  task automatic test_train_hit();
    upd(32'h1000, 1, 32'h2000, 8'h00, 0);
    upd(32'h1000, 1, 32'h2000, 8'h00, 0);
    fetch1(32'h1000);
    checks++;
    if (pred_valid[0] !== 1'b1 || pred_taken[0] !== 1'b1 || pred_target[0] !== 32'h2000 || pred_ghr !== 8'h00) begin
      failures++;
      $display("FAIL train_hit got v=%b t=%b tgt=%h ghr=%h exp 1/1/00002000/00", pred_valid[0], pred_taken[0], pred_target[0], pred_ghr);
    end
    cycle();
    checks++;
    if (pred_ghr !== 8'h01 || pred_valid !== 3'b000) begin
      failures++;
      $display("FAIL train_ghr got ghr=%h valid=%b exp 01/000", pred_ghr, pred_valid);
    end
  endtask

  task automatic test_squash();
    upd(32'h1000, 1, 32'h2000, 8'h01, 0);
    upd(32'h1000, 1, 32'h2000, 8'h01, 0);
    upd(32'h1004, 1, 32'h2004, 8'h80, 0);
    upd(32'h1008, 1, 32'h2008, 8'h80, 0);
    fetch_en = 3'b111;
    fetch_pc[0] = 32'h1000; fetch_pc[1] = 32'h1004; fetch_pc[2] = 32'h1008;
    cycle();
    idle();
    checks++;
    if (pred_valid !== 3'b001 || pred_taken !== 3'b001) begin
      failures++;
      $display("FAIL squash_valid got valid=%b taken=%b exp 001/001", pred_valid, pred_taken);
    end
    checks++;
    if (pred_target[0] !== 32'h2000 || pred_target[1] !== 32'h1008 || pred_target[2] !== 32'h100C) begin
      failures++;
      $display("FAIL squash_targets got %h %h %h exp 00002000 00001008 0000100c", pred_target[0], pred_target[1], pred_target[2]);
    end
    cycle();
    checks++;
    if (pred_ghr !== 8'h03) begin
      failures++;
      $display("FAIL squash_ghr got %h exp 03", pred_ghr);
    end
  endtask

  task automatic test_saturation();
    set_ghr(8'h40);
    repeat (4) upd(32'h3040, 1, 32'h7000, 8'h40, 0);
    upd(32'h3040, 0, 32'h0, 8'h40, 0);
    fetch1(32'h3040);
    checks++;
    if (pred_valid[0] !== 1'b1 || pred_taken[0] !== 1'b1 || pred_target[0] !== 32'h7000 || pred_ghr !== 8'h40) begin
      failures++;
      $display("FAIL sat_still_taken got v=%b t=%b tgt=%h ghr=%h exp 1/1/00007000/40", pred_valid[0], pred_taken[0], pred_target[0], pred_ghr);
    end
    set_ghr(8'h40);
    repeat (2) upd(32'h3040, 0, 32'h0, 8'h40, 0);
    fetch1(32'h3040);
    checks++;
    if (pred_valid[0] !== 1'b1 || pred_taken[0] !== 1'b0 || pred_target[0] !== 32'h3044) begin
      failures++;
      $display("FAIL sat_not_taken got v=%b t=%b tgt=%h exp 1/0/00003044", pred_valid[0], pred_taken[0], pred_target[0]);
    end
    set_ghr(8'h40);
    upd(32'h3040, 0, 32'h0, 8'h40, 0);
    upd(32'h3040, 1, 32'h7000, 8'h40, 0);
    fetch1(32'h3040);
    checks++;
    if (pred_valid[0] !== 1'b1 || pred_taken[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_floor got v=%b t=%b exp 1/0", pred_valid[0], pred_taken[0]);
    end
  endtask

  task automatic test_mispredict_repair();
    set_ghr(8'hA5);
    idle();
    fetch_en = 3'b001; fetch_pc[0] = 32'h1000;
    upd_en = 1; upd_pc = 32'h6000; upd_taken = 0; upd_ghr = 8'h3C; upd_mispredict = 1;
    cycle();
    idle();
    checks++;
    if (pred_valid[0] !== 1'b1 || pred_ghr !== 8'hA5) begin
      failures++;
      $display("FAIL repair_lookup got v=%b ghr=%h exp 1/a5", pred_valid[0], pred_ghr);
    end
    cycle();
    checks++;
    if (pred_ghr !== 8'h78) begin
      failures++;
      $display("FAIL repair_ghr got %h exp 78", pred_ghr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      fetch_en = 3'($urandom_range(0, 7));
      for (int l = 0; l < 3; l++)
        fetch_pc[l] = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 1) << 8);
      if ($urandom_range(0, 1) == 1) begin
        upd_en = 1;
        upd_pc = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 1) << 8);
        upd_taken = 1'($urandom_range(0, 1));
        upd_target = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) << 2);
        upd_ghr = ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom_range(0, 255));
        upd_mispredict = ($urandom_range(0, 3) == 0);
      end
      cycle();
      checks++;
      if (pred_valid !== e_valid || pred_taken !== e_taken || pred_ghr !== e_ghr) begin
        failures++;
        $display("FAIL rand_dir[%0d] got v=%b t=%b ghr=%h exp v=%b t=%b ghr=%h", n, pred_valid, pred_taken, pred_ghr, e_valid, e_taken, e_ghr);
      end
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (pred_target[l] !== e_tgt[l]) begin
          failures++;
          $display("FAIL rand_tgt[%0d][%0d] got %h exp %h", n, l, pred_target[l], e_tgt[l]);
        end
      end
    end
    idle();
    cycle();
    checks++;
    if (pred_valid !== 3'b000 || pred_taken !== 3'b000) begin
      failures++;
      $display("FAIL idle_clears got v=%b t=%b exp 000/000", pred_valid, pred_taken);
    end
  endtask

  task automatic test_async_reset();
    upd(32'h1000, 1, 32'h2000, 8'(m_ghr), 0);
    fetch1(32'h1000);
    checks++;
    if (pred_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL prereset_hit got v=%b exp 1", pred_valid[0]);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (pred_valid !== 3'b0 || pred_taken !== 3'b0 || pred_target !== '0 || pred_ghr !== 8'h0) begin
      failures++;
      $display("FAIL async_reset got valid=%b taken=%b ghr=%h exp zeros", pred_valid, pred_taken, pred_ghr);
    end
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    fetch1(32'h1000);
    checks++;
    if (pred_valid !== 3'b000 || pred_target[0] !== 32'h1004) begin
      failures++;
      $display("FAIL post_reset_miss got v=%b tgt=%h exp 000/00001004", pred_valid, pred_target[0]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_train_hit();
    test_squash();
    test_saturation();
    test_mispredict_repair();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised multi-lane branch predictor for the R10K front end: replaces the fixed 3-wide predictor with a direct-mapped BTB plus a gshare pattern history table (PHT) indexed by PC XOR a speculative global history register (GHR). It sits between fetch and the branch stack. Fetch presents up to FETCH_W PCs per cycle and receives registered predictions one cycle later. Resolved branches from the branch stack train the tables and, on a mispredict, repair the GHR from the history snapshot that travelled with the branch.

## Interface
- FETCH_W, 3, fetch lanes per cycle
- BTB_IDX_W, 6, log2 of BTB entries; index = pc[BTB_IDX_W+1:2]
- BTB_TAG_W, 10, tag = pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2]
- GHR_W, 8, history bits; PHT has 2^GHR_W 2-bit counters
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_en  in  FETCH_W  lane valid
- fetch_pc  in  FETCH_W x `SYS_XLEN  lane PCs
- pred_valid  out  FETCH_W  BTB hit on an enabled, unsquashed lane (registered)
- pred_taken  out  FETCH_W  predicted taken (registered)
- pred_target  out  FETCH_W x `SYS_XLEN  BTB target if taken, else pc+4 (registered)
- pred_ghr  out  GHR_W  GHR value used for this group's lookup (registered), to be stored with each branch
- upd_en  in  1  resolved-branch update valid
- upd_pc  in  `SYS_XLEN  resolved branch PC
- upd_taken  in  1  actual direction
- upd_target  in  `SYS_XLEN  actual target
- upd_ghr  in  GHR_W  pred_ghr captured at prediction time
- upd_mispredict  in  1  qualifies upd_en; forces GHR repair

## Operation
- Lookup (combinational, registered at the edge): for each lane, hit = fetch_en & btb_valid[idx] & (btb_tag[idx] == tag). PHT index = pc[GHR_W+1:2] ^ GHR. All lanes use the GHR value at the start of the cycle.
- Direction: taken = hit & (counter >= 2).
- Squash: lanes after the lowest-numbered taken lane return pred_valid = 0 and pred_taken = 0, with target = pc+4.
- Speculative GHR: at the edge, shift in one bit per surviving hit lane, in lane order (lane 0 first, shifted in as LSB). The bit is 1 if the lane is predicted taken, else 0. Up to FETCH_W shifts per cycle; zero hits leave the GHR unchanged.
- Training on upd_en:
  - PHT[upd_pc[GHR_W+1:2] ^ upd_ghr] saturates up when taken, down when not taken (range 0..3).
  - If upd_taken, the BTB entry at upd_pc is written (valid = 1, tag, target), overwriting any prior occupant.
  - A not-taken update never allocates or invalidates.
- Repair: on upd_en & upd_mispredict, GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This takes priority over the speculative shift in the same cycle. The lookup in that cycle still uses the old GHR, and its predictions are emitted normally; fetch is responsible for discarding them.
- Read-before-write: a same-cycle lookup of an entry being trained sees the pre-update BTB/PHT contents.

## Timing
- Latency: fetch inputs in cycle N, then pred_* valid throughout cycle N+1. Outputs are held only for one cycle; with fetch_en = 0, the next cycle's pred_valid/pred_taken are 0.
- An update in cycle N affects lookups issued in cycle N+1 onward.
- No backpressure: every cycle is a new lookup.
- Reset, asynchronous and taking effect immediately:
  - pred_valid, pred_taken, pred_target and pred_ghr = 0.
  - GHR = 0, all BTB valid bits = 0, all PHT counters = 01 (weakly not-taken).
- Reset asserted mid-stream discards in-flight predictions. The first lookup after deassertion is a cold miss.
- Wrap-around: the GHR is a pure shift register; the oldest bits are dropped. Counters never wrap past 0 or 3.
- Aliasing: PCs sharing an index but with different tags miss. PCs sharing a PHT index share a counter.

## Test plan
- Cold miss: release reset, then fetch lane0 pc 0x1000 -> next cycle pred_valid = 000, pred_target[0] = 0x1004, pred_ghr = 0.
- Train and hit: upd pc 0x1000, taken, target 0x2000, upd_ghr = 0, twice; then fetch 0x1000 with GHR = 0 -> pred_valid[0] = 1, pred_taken[0] = 1, pred_target[0] = 0x2000, and GHR becomes 0x01.
- Squash: lanes 0x1000 (trained taken), 0x1004 and 0x1008 (both BTB hits) -> pred_valid = 001, lanes 1-2 target = pc+4, GHR shifts by exactly one bit.
- Counter saturation: 4 taken updates followed by 1 not-taken update on the same index -> still predicted taken. Two further not-taken updates -> not taken. Rolling back past 0 is not possible.
- Mispredict repair: with the speculative GHR at 0xA5, upd_mispredict with upd_ghr = 0x3C and taken = 0 in the same cycle as a hitting fetch -> GHR = 0x78 next cycle, and the following pred_ghr = 0x78.
- Async reset mid-operation: assert rst between edges after training -> outputs are 0 immediately, and a refetch of 0x1000 after release is a miss.
